// File: rtl/timer_prog_pkg.sv
// Shared types, bus constants and command legality rules
// for the timer programming sequencer.
package timer_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_MSN,
    ST_LSN,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic       sel;
    logic [2:0] mode;
    logic [7:0] count;
  } cmd_t;

  localparam logic [1:0] ADDR_CTRL = 2'b10;
  localparam logic [1:0] ADDR_IDLE = 2'b11;

  localparam logic [7:0] C0_MIN = 8'd2;
  localparam logic [7:0] C0_MAX = 8'd150;
  localparam logic [7:0] C1_MIN = 8'd50;
  localparam logic [7:0] C1_MAX = 8'd200;

  localparam logic [2:0] MODE_RATE = 3'd2;
  localparam logic [2:0] MODE_SQW  = 3'd3;
  localparam logic [2:0] MODE_SWS  = 3'd4;
  localparam logic [2:0] MODE_MAX  = 3'd4;

  function automatic logic cmd_legal(
    input logic       sel,
    input logic [2:0] mode,
    input logic [7:0] n
  );
    logic in_rng;
    logic par_ok;
    if (sel)
      in_rng = (n >= C1_MIN) && (n <= C1_MAX);
    else
      in_rng = (n >= C0_MIN) && (n <= C0_MAX);
    // rate mode needs an even divisor, square-wave style modes an odd one
    unique case (1'b1)
      mode == MODE_RATE: par_ok = ~n[0];
      mode == MODE_SQW:  par_ok = n[0];
      mode == MODE_SWS:  par_ok = n[0];
      default:           par_ok = 1'b1;
    endcase
    return in_rng && (mode <= MODE_MAX) && par_ok;
  endfunction

endpackage

// File: rtl/timer_prog_fifo.sv
// Small synchronous command FIFO with full/empty flags.
// Push and pop on the same edge keep occupancy unchanged.
module timer_prog_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q;
  logic [AW:0]  rp_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_prog_seq.sv
// Command sequencer: checks queued timer commands and
// serialises legal ones as CTRL/MSN/LSN bus writes.
module timer_prog_seq
  import timer_prog_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_sel,
  input  logic [2:0] cmd_mode,
  input  logic [7:0] cmd_count,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic       rsp_sel,
  output logic [3:0] t_d,
  output logic [1:0] t_a,
  output logic       busy
);

  localparam logic [3:0] GAP_N = 4'(IDLE_GAP);

  state_e     state_q;
  logic       sel_q;
  logic [7:0] cnt_q;
  logic [3:0] gap_q;

  cmd_t wcmd;
  cmd_t head;
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign wcmd = '{sel: cmd_sel, mode: cmd_mode, count: cmd_count};
  assign pop  = (state_q == ST_IDLE) & ~fifo_empty;

  timer_prog_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .wdata_i (wcmd),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cmd_ready = ~fifo_full;
  assign busy      = ~fifo_empty | (state_q != ST_IDLE);

  // Bus outputs are set for the state being entered, so the
  // state register always names what the bus currently shows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      gap_q     <= '0;
      t_a       <= ADDR_IDLE;
      t_d       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_sel   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (cmd_legal(head.sel, head.mode, head.count)) begin
              sel_q   <= head.sel;
              cnt_q   <= head.count;
              state_q <= ST_CTRL;
              t_a     <= ADDR_CTRL;
              t_d     <= {head.sel, head.mode};
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_sel   <= head.sel;
            end
          end
        end
        ST_CTRL: begin
          state_q <= ST_MSN;
          t_a     <= {1'b0, sel_q};
          t_d     <= cnt_q[7:4];
        end
        ST_MSN: begin
          state_q <= ST_LSN;
          t_d     <= cnt_q[3:0];
        end
        ST_LSN: begin
          t_a       <= ADDR_IDLE;
          t_d       <= '0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_sel   <= sel_q;
          if (GAP_N != 4'd0) begin
            state_q <= ST_GAP;
            gap_q   <= GAP_N - 4'd1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_q == 4'd0) state_q <= ST_IDLE;
          else               gap_q   <= gap_q - 4'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_prog_seq.sv
// Scoreboard bench for timer_prog_seq: driver queues expected
// bus writes and responses, a negedge monitor checks them.
module tb_timer_prog_seq;

  localparam int DEPTH = 2;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_sel = 1'b0;
  logic [2:0] cmd_mode = '0;
  logic [7:0] cmd_count = '0;
  logic       cmd_ready, rsp_valid, rsp_err, rsp_sel, busy;
  logic [3:0] t_d;
  logic [1:0] t_a;

  logic       v2 = 1'b0;
  logic       sel2 = 1'b0;
  logic [2:0] mode2 = '0;
  logic [7:0] n2 = '0;
  logic       ready2, rv2, re2, rs2, busy2;
  logic [3:0] td2;
  logic [1:0] ta2;

  always #5 clk = ~clk;

  timer_prog_seq #(.DEPTH(DEPTH), .IDLE_GAP(GAP)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_mode(cmd_mode), .cmd_count(cmd_count),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_sel(rsp_sel),
    .t_d(t_d), .t_a(t_a), .busy(busy)
  );

  timer_prog_seq #(.DEPTH(DEPTH), .IDLE_GAP(0)) u_dut_g0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(v2), .cmd_ready(ready2),
    .cmd_sel(sel2), .cmd_mode(mode2), .cmd_count(n2),
    .rsp_valid(rv2), .rsp_err(re2), .rsp_sel(rs2),
    .t_d(td2), .t_a(ta2), .busy(busy2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference legality from the range/parity rules
  function automatic bit legal_ref(int s, int m, int n);
    int lo, hi;
    lo = s ? 50 : 2;
    hi = s ? 200 : 150;
    if (m > 4 || n < lo || n > hi) return 0;
    if (m == 2) return (n % 2) == 0;
    if (m == 3 || m == 4) return (n % 2) == 1;
    return 1;
  endfunction

  logic [11:0] bus_q[$];
  logic [1:0]  rsp_q[$];
  int          ctrl_t[$];
  int          ctrl2[$];
  int          cyc = 0;
  int          occ = 0;
  int          phase = 0;
  int          gap_left = 0;
  int          rsp2_n = 0;
  bit          want_rsp = 0;
  bit          push_evt = 0;
  bit          stall_seen = 0;
  logic [11:0] cur = '0;

  always @(posedge clk) cyc++;

  task automatic send(input int s, input int m, input int n);
    bit acc;
    bit lg;
    int k;
    acc = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_sel   = 1'(s);
    cmd_mode  = 3'(m);
    cmd_count = 8'(n);
    for (k = 0; k < 200; k++) begin
      acc = cmd_ready;
      if (!acc) stall_seen = 1;
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    if (!acc) begin
      chk("accept_timeout", 0, 1);
    end else begin
      lg = legal_ref(s, m, n);
      push_evt = 1;
      rsp_q.push_back({~lg, 1'(s)});
      if (lg) bus_q.push_back({1'(s), 3'(m), 8'(n)});
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (!busy && rsp_q.size() == 0 && bus_q.size() == 0 &&
          !want_rsp && phase == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge clk);
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    bit pop;
    bit exp_busy;
    if (!rst_n) begin
      bus_q.delete();
      rsp_q.delete();
      occ = 0;
      phase = 0;
      gap_left = 0;
      want_rsp = 0;
      push_evt = 0;
    end else begin
      pop = (t_a == 2'b10) || (rsp_valid && rsp_err);
      occ = occ + int'(push_evt) - int'(pop);
      push_evt = 0;
      chk("cmd_ready", cmd_ready, occ < DEPTH);

      if (rsp_valid) begin
        chk("rsp_bus_idle", t_a, 2'b11);
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_err", rsp_err, e[1]);
          chk("rsp_sel", rsp_sel, e[0]);
          chk("rsp_timing", want_rsp, !e[1]);
          if (!e[1]) gap_left = GAP;
        end
      end else if (want_rsp) begin
        chk("rsp_missing", 0, 1);
      end
      want_rsp = 0;

      if (t_a == 2'b10) begin
        chk("ctrl_phase", phase, 0);
        ctrl_t.push_back(cyc);
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", 1, 0);
          phase = 0;
        end else begin
          cur = bus_q.pop_front();
          chk("ctrl_d", t_d, cur[11:8]);
          phase = 1;
        end
      end else if (t_a == 2'b11) begin
        chk("idle_d", t_d, 0);
        if (phase != 0) begin
          chk("seq_truncated", phase, 0);
          phase = 0;
        end
      end else if (phase == 0) begin
        chk("bus_stray", t_a, 2'b11);
      end else begin
        chk("data_addr", t_a, {1'b0, cur[11]});
        if (phase == 1) begin
          chk("msn_d", t_d, cur[7:4]);
          phase = 2;
        end else begin
          chk("lsn_d", t_d, cur[3:0]);
          phase = 0;
          want_rsp = 1;
        end
      end

      exp_busy = (occ != 0) || (t_a != 2'b11) || (gap_left > 0);
      chk("busy", busy, exp_busy);
      if (gap_left > 0) gap_left--;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ta2 == 2'b10) ctrl2.push_back(cyc);
      if (rv2) begin
        rsp2_n++;
        chk("g0_rsp_err", re2, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int s, m, n;
    bit found;
    int bnd[12];
    bnd = '{1, 2, 3, 49, 50, 51, 149, 150, 151, 199, 200, 201};

    repeat (3) @(negedge clk);
    chk("rst_ta", t_a, 2'b11);
    chk("rst_td", t_d, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_sel", rsp_sel, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // single legal command: latency and bus contents
    send(0, 0, 100);
    @(negedge clk);
    chk("lat_t1_idle", t_a, 2'b11);
    @(negedge clk);
    chk("lat_ctrl_a", t_a, 2'b10);
    chk("lat_ctrl_d", t_d, 4'h0);
    @(negedge clk);
    chk("lat_msn_d", t_d, 4'h6);
    @(negedge clk);
    chk("lat_lsn_d", t_d, 4'h4);
    @(negedge clk);
    chk("lat_rsp", {rsp_valid, rsp_err, t_a}, 4'b1011);
    wait_idle();

    send(1, 3, 151);
    wait_idle();

    // illegal commands
    send(0, 2, 7);
    @(negedge clk);
    chk("ill_t1", rsp_valid, 0);
    @(negedge clk);
    chk("ill_rsp", {rsp_valid, rsp_err}, 2'b11);
    send(1, 0, 49);
    send(0, 5, 10);
    wait_idle();

    // back-to-back with a shallow FIFO
    ctrl_t.delete();
    stall_seen = 0;
    send(0, 0, 100);
    send(1, 1, 60);
    send(0, 2, 40);
    send(1, 4, 101);
    wait_idle();
    chk("b2b_stall", stall_seen, 1);
    chk("b2b_count", ctrl_t.size(), 4);
    if (ctrl_t.size() == 4)
      for (int i = 1; i < 4; i++)
        chk("b2b_spacing", ctrl_t[i] - ctrl_t[i-1], 4 + GAP);

    // reset in the middle of a sequence
    send(0, 1, 77);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (t_a == 2'b00) begin
        found = 1;
        break;
      end
    end
    chk("msn_reached", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ta", t_a, 2'b11);
    chk("arst_td", t_d, 0);
    chk("arst_rsp", rsp_valid, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    send(1, 2, 80);
    wait_idle();

    // randomized traffic near the range and parity edges
    for (int i = 0; i < 60; i++) begin
      s = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) m = $urandom_range(5, 7);
      else m = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 0) n = $urandom_range(0, 255);
      else n = bnd[$urandom_range(0, 11)];
      send(s, m, n);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    wait_idle();
    chk("sb_bus_empty", bus_q.size(), 0);
    chk("sb_rsp_empty", rsp_q.size(), 0);

    // zero idle gap: sequences four cycles apart
    ctrl2.delete();
    rsp2_n = 0;
    @(negedge clk);
    v2 = 1'b1;
    sel2 = 1'b0;
    mode2 = 3'd0;
    n2 = 8'd100;
    @(posedge clk);
    #1;
    sel2 = 1'b1;
    mode2 = 3'd1;
    n2 = 8'd60;
    @(posedge clk);
    #1 v2 = 1'b0;
    repeat (20) @(negedge clk);
    chk("g0_ctrl_count", ctrl2.size(), 2);
    if (ctrl2.size() == 2)
      chk("g0_spacing", ctrl2[1] - ctrl2[0], 4);
    chk("g0_rsp_count", rsp2_n, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
